mem_arbiter: RTL and testbench

- Round-robin arbiter and access sequencer that shares the single-port unified word memory (combinational read, posedge-clk write) between the instruction-fetch requester and the load/store requester.
- Sits between the multicycle core's fetch/data units and the memory.
- Accepts one request at a time, drives the memory for exactly one cycle, then returns registered read data with a valid/error pulse.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request-side and memory-side signal bundle for mem_arbiter.
// The arbiter takes the slave view; the core and memory model take the master view.
interface mem_arbiter_if #(
    parameter int N = 32
);
    logic         i_req;
    logic [N-1:0] i_addr;
    logic         i_gnt;
    logic         i_rvalid;
    logic [N-1:0] i_rdata;
    logic         i_err;

    logic         d_req;
    logic         d_we;
    logic [N-1:0] d_addr;
    logic [N-1:0] d_wdata;
    logic         d_gnt;
    logic         d_rvalid;
    logic [N-1:0] d_rdata;
    logic         d_err;

    logic         mem_we;
    logic [N-1:0] mem_a;
    logic [N-1:0] mem_wd;
    logic [N-1:0] mem_rd;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        output i_gnt, i_rvalid, i_rdata, i_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_we, mem_a, mem_wd
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between fetch and load/store.
// One request is granted in IDLE, the memory is driven for one ACCESS cycle, then a registered response pulses.
module mem_arbiter #(
    parameter int N = 32,
    parameter int L = 64
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic { IDLE, ACCESS } state_t;
    typedef enum logic { FETCH = 1'b0, DATA = 1'b1 } req_id_t;

    localparam logic [N-3:0] L_IDX = (N-2)'(L);

    state_t       state_q, state_d;
    req_id_t      last_grant_q, last_grant_d;
    req_id_t      req_id_q, req_id_d;
    logic         we_q, we_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;

    logic         i_rvalid_q, i_rvalid_d;
    logic [N-1:0] i_rdata_q, i_rdata_d;
    logic         i_err_q, i_err_d;
    logic         d_rvalid_q, d_rvalid_d;
    logic [N-1:0] d_rdata_q, d_rdata_d;
    logic         d_err_q, d_err_d;

    logic         grant_i, grant_d;
    logic         aligned, in_range, access_ok, in_access;
    logic [N-1:0] resp_rdata;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (bus.i_req && (!bus.d_req || last_grant_q == DATA)) begin
                grant_i = 1'b1;
            end else if (bus.d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    assign in_access  = (state_q == ACCESS);
    assign aligned    = (addr_q[1:0] == 2'b00);
    assign in_range   = (addr_q[N-1:2] < L_IDX);
    assign access_ok  = aligned && in_range;
    assign resp_rdata = (we_q || !access_ok) ? '0 : bus.mem_rd;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_id_d     = req_id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rvalid_d   = 1'b0;
        i_rdata_d    = i_rdata_q;
        i_err_d      = i_err_q;
        d_rvalid_d   = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_err_d      = d_err_q;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d      = ACCESS;
                    last_grant_d = FETCH;
                    req_id_d     = FETCH;
                    we_d         = 1'b0;
                    addr_d       = bus.i_addr;
                    wdata_d      = '0;
                end else if (grant_d) begin
                    state_d      = ACCESS;
                    last_grant_d = DATA;
                    req_id_d     = DATA;
                    we_d         = bus.d_we;
                    addr_d       = bus.d_addr;
                    wdata_d      = bus.d_wdata;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (req_id_q == FETCH) begin
                    i_rvalid_d = 1'b1;
                    i_rdata_d  = resp_rdata;
                    i_err_d    = !access_ok;
                end else begin
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = resp_rdata;
                    d_err_d    = !access_ok;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset in ACCESS drops the in-flight transaction without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= DATA;
            req_id_q     <= FETCH;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            i_err_q      <= 1'b0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= '0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_id_q     <= req_id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rvalid_q   <= i_rvalid_d;
            i_rdata_q    <= i_rdata_d;
            i_err_q      <= i_err_d;
            d_rvalid_q   <= d_rvalid_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
        end
    end

    assign bus.i_gnt    = grant_i;
    assign bus.d_gnt    = grant_d;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.i_err    = i_err_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_err    = d_err_q;

    assign bus.mem_we = in_access && we_q && access_ok && !reset;
    assign bus.mem_a  = in_access ? addr_q : '0;
    assign bus.mem_wd = in_access ? wdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 64-word memory model with combinational read
// and posedge write, driven through fetch-only, store/load, contention, error and reset-abort scenarios.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] mem [64];

    mem_arbiter_if #(.N(32)) bus ();

    mem_arbiter #(.N(32), .L(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out-of-range reads return a poison pattern so zeroed error data is observable.
    assign bus.mem_rd = (bus.mem_a[31:2] < 30'd64) ? mem[bus.mem_a[7:2]] : 32'hBADBAD00;

    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_a[31:2] < 30'd64) mem[bus.mem_a[7:2]] <= bus.mem_wd;
    end

    task automatic clear_inputs();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        #1;
        checks++; if (bus.i_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_i_gnt: got %b, expected 0", bus.i_gnt); end
        checks++; if (bus.d_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_gnt: got %b, expected 0", bus.d_gnt); end
        checks++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got i=%b d=%b, expected 0 0", bus.i_rvalid, bus.d_rvalid); end
        checks++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got i=%h d=%h, expected 0 0", bus.i_rdata, bus.d_rdata); end
        checks++; if (bus.i_err !== 1'b0 || bus.d_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got i=%b d=%b, expected 0 0", bus.i_err, bus.d_err); end
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_a !== 32'h0 || bus.mem_wd !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem: got we=%b a=%h wd=%h, expected 0 0 0", bus.mem_we, bus.mem_a, bus.mem_wd); end
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_fetch_only();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h8;
        #1;
        checks++; if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin errors++; $display("[TB] FAIL fetch_gnt: got i=%b d=%b, expected 1 0", bus.i_gnt, bus.d_gnt); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_we_T: got %b, expected 0", bus.mem_we); end
        @(negedge clk);
        bus.i_req = 1'b0;
        #1;
        checks++; if (bus.mem_a !== 32'h8) begin errors++; $display("[TB] FAIL fetch_mem_a: got %h, expected 00000008", bus.mem_a); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_we_T1: got %b, expected 0", bus.mem_we); end
        checks++; if (bus.i_gnt !== 1'b0) begin errors++; $display("[TB] FAIL fetch_gnt_access: got %b, expected 0", bus.i_gnt); end
        @(negedge clk);
        #1;
        checks++; if (bus.i_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_rvalid: got %b, expected 1", bus.i_rvalid); end
        checks++; if (bus.i_rdata !== 32'h20020005) begin errors++; $display("[TB] FAIL fetch_rdata: got %h, expected 20020005", bus.i_rdata); end
        checks++; if (bus.i_err !== 1'b0) begin errors++; $display("[TB] FAIL fetch_err: got %b, expected 0", bus.i_err); end
        checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_d_rvalid: got %b, expected 0", bus.d_rvalid); end
        @(negedge clk);
        #1;
        checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_rvalid_pulse: got %b, expected 0", bus.i_rvalid); end
        checks++; if (bus.i_rdata !== 32'h20020005) begin errors++; $display("[TB] FAIL fetch_rdata_hold: got %h, expected 20020005", bus.i_rdata); end
        @(negedge clk);
    endtask

    task automatic test_store_load();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h54;
        bus.d_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0) begin errors++; $display("[TB] FAIL store_gnt: got d=%b i=%b, expected 1 0", bus.d_gnt, bus.i_gnt); end
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_a !== 32'h54 || bus.mem_wd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL store_mem: got we=%b a=%h wd=%h, expected 1 00000054 deadbeef", bus.mem_we, bus.mem_a, bus.mem_wd); end
        @(negedge clk);
        #1;
        checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0 || bus.d_err !== 1'b0) begin errors++; $display("[TB] FAIL store_resp: got v=%b rd=%h e=%b, expected 1 00000000 0", bus.d_rvalid, bus.d_rdata, bus.d_err); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL store_we_once: got %b, expected 0", bus.mem_we); end
        checks++; if (mem[21] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL store_written: got %h, expected deadbeef", mem[21]); end
        bus.d_req = 1'b1;
        bus.d_we  = 1'b0;
        #1;
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("[TB] FAIL load_gnt: got %b, expected 1", bus.d_gnt); end
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_a !== 32'h54) begin errors++; $display("[TB] FAIL load_mem: got we=%b a=%h, expected 0 00000054", bus.mem_we, bus.mem_a); end
        @(negedge clk);
        #1;
        checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF || bus.d_err !== 1'b0) begin errors++; $display("[TB] FAIL load_resp: got v=%b rd=%h e=%b, expected 1 deadbeef 0", bus.d_rvalid, bus.d_rdata, bus.d_err); end
        checks++; if (bus.i_rdata !== 32'h20020005) begin errors++; $display("[TB] FAIL load_i_rdata_hold: got %h, expected 20020005", bus.i_rdata); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic exp_ig, exp_dg, exp_iv, exp_dv;
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h4;
        for (int k = 0; k < 8; k++) begin
            exp_ig = (k == 0) || (k == 4);
            exp_dg = (k == 2) || (k == 6);
            exp_iv = (k == 2) || (k == 6);
            exp_dv = (k == 4);
            #1;
            checks++; if (bus.i_gnt !== exp_ig || bus.d_gnt !== exp_dg) begin errors++; $display("[TB] FAIL contention_gnt[%0d]: got i=%b d=%b, expected %b %b", k, bus.i_gnt, bus.d_gnt, exp_ig, exp_dg); end
            checks++; if (bus.i_rvalid !== exp_iv || bus.d_rvalid !== exp_dv) begin errors++; $display("[TB] FAIL contention_rvalid[%0d]: got i=%b d=%b, expected %b %b", k, bus.i_rvalid, bus.d_rvalid, exp_iv, exp_dv); end
            if (k == 2) begin
                checks++; if (bus.i_rdata !== 32'h11111111) begin errors++; $display("[TB] FAIL contention_i_rdata: got %h, expected 11111111", bus.i_rdata); end
            end
            if (k == 4) begin
                checks++; if (bus.d_rdata !== 32'h22222222) begin errors++; $display("[TB] FAIL contention_d_rdata: got %h, expected 22222222", bus.d_rdata); end
            end
            @(negedge clk);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_errors();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h56;
        bus.d_wdata = 32'h12345678;
        #1;
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("[TB] FAIL err_store_gnt: got %b, expected 1", bus.d_gnt); end
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL err_store_we: got %b, expected 0", bus.mem_we); end
        @(negedge clk);
        #1;
        checks++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL err_store_resp: got v=%b e=%b rd=%h, expected 1 1 00000000", bus.d_rvalid, bus.d_err, bus.d_rdata); end
        checks++; if (mem[21] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL err_store_mem: got %h, expected deadbeef", mem[21]); end
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        #1;
        checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("[TB] FAIL err_fetch_gnt: got %b, expected 1", bus.i_gnt); end
        @(negedge clk);
        bus.i_req = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.i_rvalid !== 1'b1 || bus.i_err !== 1'b1 || bus.i_rdata !== 32'h0) begin errors++; $display("[TB] FAIL err_fetch_resp: got v=%b e=%b rd=%h, expected 1 1 00000000", bus.i_rvalid, bus.i_err, bus.i_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_access();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h10;
        bus.d_wdata = 32'hCAFEF00D;
        #1;
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("[TB] FAIL abort_gnt: got %b, expected 1", bus.d_gnt); end
        @(negedge clk);
        bus.d_req = 1'b0;
        reset     = 1'b1;
        #1;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL abort_we: got %b, expected 0", bus.mem_we); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL abort_rvalid: got %b, expected 0", bus.d_rvalid); end
        checks++; if (mem[4] !== 32'h44444444) begin errors++; $display("[TB] FAIL abort_mem: got %h, expected 44444444", mem[4]); end
        bus.d_req = 1'b1;
        bus.d_we  = 1'b0;
        #1;
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("[TB] FAIL abort_idle_gnt: got %b, expected 1", bus.d_gnt); end
        @(negedge clk);
        bus.d_req = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h44444444 || bus.d_err !== 1'b0) begin errors++; $display("[TB] FAIL abort_reload: got v=%b rd=%h e=%b, expected 1 44444444 0", bus.d_rvalid, bus.d_rdata, bus.d_err); end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h20020005;
        mem[4] = 32'h44444444;

        test_reset();
        test_fetch_only();
        test_store_load();
        test_contention();
        test_errors();
        test_reset_in_access();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
